// File: rtl/param_div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package param_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/param_div_div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left, trial-subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           ge;

  // rem_i < dvs_i always holds, so the shifted value is below 2*dvs and a
  // WIDTH+1-bit difference has a trustworthy sign bit.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    ge      = ~trial[WIDTH];
    rem_o   = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/param_div.sv
// Sequential signed/unsigned divider: WIDTH+1 cycles per nonzero divide, 1 cycle to result for b==0.
// Backpressure: start is only honoured in IDLE; requests while busy or fixing up are dropped.
module param_div
  import param_div_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    a_raw_d    = a_raw_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    signed_d   = signed_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    signed_op = SIGNED_EN ? is_signed : 1'b0;
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_a_d   = a_neg;
          sign_b_d   = b_neg;
          signed_d   = signed_op;
          quo_d      = a_neg ? -a : a;
          dvs_d      = b_neg ? -b : b;
          rem_d      = '0;
          cnt_d      = CNT_INIT;
          a_raw_d    = a;
          div_zero_d = 1'b0;
          state_d    = (b == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
        // A zero divisor has a zero magnitude, and no nonzero divisor does.
        if (dvs_q == '0) begin
          lo_d       = '1;
          hi_d       = a_raw_q;
          div_zero_d = 1'b1;
        end else begin
          lo_d = (signed_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
          hi_d = (signed_q && sign_a_q) ? -rem_q : rem_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      a_raw_q    <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      signed_q   <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      a_raw_q    <= a_raw_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      signed_q   <= signed_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign lo       = lo_q;
  assign hi       = hi_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule
